// File: rtl/ysyx_23060136_idu_csr_mp_file.sv
// Multi-port M-mode CSR file: NUM_WR prioritised write channels, NUM_RD combinational read ports,
// hardware mcycle/minstret, atomic trap-entry/mret. Define CSR_BYPASS_EN to forward same-cycle writes to reads.
module ysyx_23060136_idu_csr_mp_file #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CSR_AW = 3,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned RET_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*CSR_AW-1:0] wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic [NUM_RD*CSR_AW-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic [RET_W-1:0]         retire_cnt,
    input  logic                     trap_valid,
    input  logic [XLEN-1:0]          trap_pc,
    input  logic [XLEN-1:0]          trap_cause,
    input  logic                     mret_valid,
    output logic [XLEN-1:0]          mtvec_o,
    output logic [XLEN-1:0]          mepc_o,
    output logic                     mie_o
);

    localparam int unsigned NUM_CSR    = 8;
    localparam int unsigned ADDR_SPACE = 1 << CSR_AW;

    localparam int unsigned I_MSTATUS   = 0;
    localparam int unsigned I_MTVEC     = 1;
    localparam int unsigned I_MEPC      = 2;
    localparam int unsigned I_MCAUSE    = 3;
    localparam int unsigned I_MVENDORID = 4;
    localparam int unsigned I_MARCHID   = 5;
    localparam int unsigned I_MCYCLE    = 6;
    localparam int unsigned I_MINSTRET  = 7;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;
    localparam int unsigned MPP_LO   = 11;
    localparam int unsigned MPP_HI   = 12;

    localparam logic [XLEN-1:0] MSTATUS_RST   = XLEN'(64'h0000_000a_0000_1800);
    localparam logic [XLEN-1:0] MVENDORID_RST = XLEN'(64'h7973_7978_015F_DEA8);
    localparam logic [XLEN-1:0] MARCHID_RST   = XLEN'(64'h4C4A_5100_0CA0_E255);

    // mvendorid and marchid are read-only
    localparam logic [NUM_CSR-1:0] WRITABLE = 8'b1100_1111;

    logic [XLEN-1:0]    csr_q    [NUM_CSR];
    logic [XLEN-1:0]    csr_d    [NUM_CSR];
    logic [XLEN-1:0]    csr_view [ADDR_SPACE];
    logic [NUM_CSR-1:0] wr_hit;
    logic [XLEN-1:0]    wr_val   [NUM_CSR];

    // Resolve write channels per CSR; lower channel index overrides higher
    always_comb begin
        for (int i = 0; i < NUM_CSR; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
        end
        for (int k = NUM_WR - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                if (wr_en[k] && WRITABLE[i] && (wr_addr[k*CSR_AW +: CSR_AW] == CSR_AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Next-state: software write, then counter increment if not written, then trap/mret field updates
    always_comb begin
        for (int i = 0; i < NUM_CSR; i++) begin
            csr_d[i] = wr_hit[i] ? wr_val[i] : csr_q[i];
        end

        if (!wr_hit[I_MCYCLE]) begin
            csr_d[I_MCYCLE] = csr_q[I_MCYCLE] + XLEN'(1);
        end
        if (!wr_hit[I_MINSTRET]) begin
            csr_d[I_MINSTRET] = csr_q[I_MINSTRET] + XLEN'(retire_cnt);
        end

        if (trap_valid) begin
            csr_d[I_MEPC]                       = trap_pc;
            csr_d[I_MCAUSE]                     = trap_cause;
            csr_d[I_MSTATUS][MPIE_BIT]          = csr_q[I_MSTATUS][MIE_BIT];
            csr_d[I_MSTATUS][MIE_BIT]           = 1'b0;
            csr_d[I_MSTATUS][MPP_HI:MPP_LO]     = 2'b11;
        end else if (mret_valid) begin
            csr_d[I_MSTATUS][MIE_BIT]           = csr_q[I_MSTATUS][MPIE_BIT];
            csr_d[I_MSTATUS][MPIE_BIT]          = 1'b1;
            csr_d[I_MSTATUS][MPP_HI:MPP_LO]     = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_q[I_MSTATUS]   <= MSTATUS_RST;
            csr_q[I_MTVEC]     <= '0;
            csr_q[I_MEPC]      <= '0;
            csr_q[I_MCAUSE]    <= '0;
            csr_q[I_MVENDORID] <= MVENDORID_RST;
            csr_q[I_MARCHID]   <= MARCHID_RST;
            csr_q[I_MCYCLE]    <= '0;
            csr_q[I_MINSTRET]  <= '0;
        end else begin
            csr_q <= csr_d;
        end
    end

    // Unmapped indices read as zero
    for (genvar i = 0; i < ADDR_SPACE; i++) begin : g_view
        if (i < NUM_CSR) begin : g_map
            assign csr_view[i] = csr_q[i];
        end else begin : g_zero
            assign csr_view[i] = '0;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [CSR_AW-1:0] addr;
        logic [XLEN-1:0]   val;

        assign addr = rd_addr[j*CSR_AW +: CSR_AW];
`ifdef CSR_BYPASS_EN
        // Forward only the winning software write; counter and trap updates stay registered
        always_comb begin
            val = csr_view[addr];
            for (int i = 0; i < NUM_CSR; i++) begin
                if (wr_hit[i] && (addr == CSR_AW'(i))) begin
                    val = wr_val[i];
                end
            end
        end
`else
        assign val = csr_view[addr];
`endif
        assign rd_data[j*XLEN +: XLEN] = val;
    end

    assign mtvec_o = csr_q[I_MTVEC];
    assign mepc_o  = csr_q[I_MEPC];
    assign mie_o   = csr_q[I_MSTATUS][MIE_BIT];

endmodule

// File: tb/tb_ysyx_23060136_idu_csr_mp_file.sv
// Self-checking bench for ysyx_23060136_idu_csr_mp_file: directed steps then random traffic against a CSR model.
module tb_ysyx_23060136_idu_csr_mp_file;

    logic         clk;
    logic         rst_n;
    logic [1:0]   wr_en;
    logic [5:0]   wr_addr;
    logic [127:0] wr_data;
    logic [5:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   retire_cnt;
    logic         trap_valid;
    logic [63:0]  trap_pc;
    logic [63:0]  trap_cause;
    logic         mret_valid;
    logic [63:0]  mtvec_o;
    logic [63:0]  mepc_o;
    logic         mie_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] m     [8];
    logic [63:0] m_nxt [8];

    localparam logic [63:0] RST_MSTATUS   = 64'h0000_000a_0000_1800;
    localparam logic [63:0] RST_MVENDORID = 64'h7973_7978_015F_DEA8;
    localparam logic [63:0] RST_MARCHID   = 64'h4C4A_5100_0CA0_E255;

    ysyx_23060136_idu_csr_mp_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .retire_cnt (retire_cnt),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .trap_cause (trap_cause),
        .mret_valid (mret_valid),
        .mtvec_o    (mtvec_o),
        .mepc_o     (mepc_o),
        .mie_o      (mie_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural view of a read: registered CSR, or this cycle's winning write when forwarding is built in
    function automatic logic [63:0] exp_read(int a);
`ifdef CSR_BYPASS_EN
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k] && int'(wr_addr[k*3 +: 3]) == a && a != 4 && a != 5)
                return wr_data[k*64 +: 64];
        end
`endif
        return m[a];
    endfunction

    // Next architectural state from the current inputs
    task automatic model_step();
        bit claimed [8];
        int a;
        for (int i = 0; i < 8; i++) begin
            m_nxt[i]   = m[i];
            claimed[i] = 1'b0;
        end
        if (!rst_n) begin
            m_nxt[0] = RST_MSTATUS;
            m_nxt[1] = '0; m_nxt[2] = '0; m_nxt[3] = '0;
            m_nxt[4] = RST_MVENDORID;
            m_nxt[5] = RST_MARCHID;
            m_nxt[6] = '0; m_nxt[7] = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                a = int'(wr_addr[k*3 +: 3]);
                if (wr_en[k] && a != 4 && a != 5 && !claimed[a]) begin
                    m_nxt[a]   = wr_data[k*64 +: 64];
                    claimed[a] = 1'b1;
                end
            end
            if (!claimed[6]) m_nxt[6] = m[6] + 64'd1;
            if (!claimed[7]) m_nxt[7] = m[7] + 64'(retire_cnt);
            if (trap_valid) begin
                m_nxt[2]        = trap_pc;
                m_nxt[3]        = trap_cause;
                m_nxt[0][7]     = m[0][3];
                m_nxt[0][3]     = 1'b0;
                m_nxt[0][12:11] = 2'b11;
            end else if (mret_valid) begin
                m_nxt[0][3]     = m[0][7];
                m_nxt[0][7]     = 1'b1;
                m_nxt[0][12:11] = 2'b11;
            end
        end
    endtask

    task automatic drive_cycle(string tag);
        #1;
        chk({tag, ".rd0"},  rd_data[63:0],   exp_read(int'(rd_addr[2:0])));
        chk({tag, ".rd1"},  rd_data[127:64], exp_read(int'(rd_addr[5:3])));
        chk({tag, ".mtvec"}, mtvec_o, m[1]);
        chk({tag, ".mepc"},  mepc_o,  m[2]);
        chk({tag, ".mie"},   64'(mie_o), 64'(m[0][3]));
        model_step();
        @(posedge clk);
        #1;
        m = m_nxt;
    endtask

    task automatic check_all(string tag);
        logic [5:0] saved;
        saved = rd_addr;
        for (int i = 0; i < 8; i += 2) begin
            rd_addr = {3'(i + 1), 3'(i)};
            #1;
            chk($sformatf("%s.csr%0d", tag, i),     rd_data[63:0],   exp_read(i));
            chk($sformatf("%s.csr%0d", tag, i + 1), rd_data[127:64], exp_read(i + 1));
        end
        rd_addr = saved;
    endtask

    task automatic idle();
        wr_en = '0; retire_cnt = '0; trap_valid = 1'b0; mret_valid = 1'b0;
    endtask

    task automatic read_pair(logic [2:0] a0, logic [2:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        trap_pc = '0; trap_cause = '0;
        idle();
        for (int i = 0; i < 8; i++) m[i] = '0;

        // Reset for one edge
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
        m = m_nxt;
        rst_n = 1'b1;
        read_pair(3'd0, 3'd4);
        chk("rst.mstatus",   rd_data[63:0],   RST_MSTATUS);
        chk("rst.mvendorid", rd_data[127:64], RST_MVENDORID);
        read_pair(3'd6, 3'd5);
        chk("rst.mcycle",    rd_data[63:0],   64'd0);
        chk("rst.marchid",   rd_data[127:64], RST_MARCHID);
        check_all("rst");
        drive_cycle("cyc1");
        read_pair(3'd6, 3'd7);
        chk("cyc1.mcycle", rd_data[63:0], 64'd1);

        // Same-index dual write: channel 0 wins; read-only target ignored
        wr_en = 2'b11; wr_addr = {3'd1, 3'd1};
        wr_data = {64'hBBBB_0000_0000_BBBB, 64'hAAAA_0000_0000_AAAA};
        drive_cycle("dualwr");
        idle();
        chk("dualwr.mtvec", mtvec_o, 64'hAAAA_0000_0000_AAAA);
        wr_en = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {64'd0, 64'hDEAD_BEEF_DEAD_BEEF};
        drive_cycle("rowr");
        idle();
        read_pair(3'd4, 3'd5);
        chk("rowr.mvendorid", rd_data[63:0], RST_MVENDORID);

        // Trap entry with MIE set
        wr_en = 2'b01; wr_addr = {3'd0, 3'd0}; wr_data = {64'd0, 64'h0000_000a_0000_0008};
        drive_cycle("setmie");
        idle();
        chk("setmie.mie", 64'(mie_o), 64'd1);
        trap_valid = 1'b1; trap_pc = 64'h8000_0100; trap_cause = 64'hB;
        drive_cycle("trap");
        idle();
        read_pair(3'd3, 3'd0);
        chk("trap.mepc",    mepc_o, 64'h8000_0100);
        chk("trap.mcause",  rd_data[63:0],   64'hB);
        chk("trap.mstatus", rd_data[127:64], 64'h0000_000a_0000_1880);
        chk("trap.mie",     64'(mie_o), 64'd0);

        // mret, then trap and mret together
        mret_valid = 1'b1;
        drive_cycle("mret");
        idle();
        read_pair(3'd0, 3'd0);
        chk("mret.mstatus", rd_data[63:0], 64'h0000_000a_0000_1888);
        trap_valid = 1'b1; mret_valid = 1'b1; trap_pc = 64'h9000; trap_cause = 64'h3;
        drive_cycle("trapmret");
        idle();
        read_pair(3'd0, 3'd3);
        chk("trapmret.mstatus", rd_data[63:0],   64'h0000_000a_0000_1880);
        chk("trapmret.mcause",  rd_data[127:64], 64'h3);
        chk("trapmret.mepc",    mepc_o, 64'h9000);

        // Counter overrides and wrap
        wr_en = 2'b11; wr_addr = {3'd7, 3'd6}; wr_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        retire_cnt = 2'd3;
        drive_cycle("cntwr");
        idle();
        read_pair(3'd6, 3'd7);
        chk("cntwr.mcycle",   rd_data[63:0],   64'hFFFF_FFFF_FFFF_FFFF);
        chk("cntwr.minstret", rd_data[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        retire_cnt = 2'd2;
        drive_cycle("wrap");
        idle();
        read_pair(3'd6, 3'd7);
        chk("wrap.mcycle",   rd_data[63:0],   64'd0);
        chk("wrap.minstret", rd_data[127:64], 64'd1);

        // Same-cycle write/read of mepc
        wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = {64'd0, 64'h1234};
        read_pair(3'd2, 3'd2);
`ifdef CSR_BYPASS_EN
        chk("byp.mepc", rd_data[63:0], 64'h1234);
`else
        chk("byp.mepc", rd_data[63:0], 64'h9000);
`endif
        drive_cycle("byp");
        idle();
        chk("byp.mepc_after", mepc_o, 64'h1234);
        check_all("directed");

        // Random traffic, occasional reset mid-operation
        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 63) != 0);
            wr_en      = 2'($urandom);
            wr_addr    = 6'($urandom);
            wr_data    = {$urandom, $urandom, $urandom, $urandom};
            rd_addr    = 6'($urandom);
            retire_cnt = 2'($urandom);
            trap_valid = ($urandom_range(0, 7) == 0);
            mret_valid = ($urandom_range(0, 7) == 0);
            trap_pc    = {$urandom, $urandom};
            trap_cause = {$urandom, $urandom};
            if ((n % 8) == 0) check_all("rnd");
            drive_cycle("rnd");
        end
        rst_n = 1'b1;
        idle();
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
